memctrl_host_master: RTL and testbench

- Host-side initiator for the MEMCTRL SRAM pin protocol. Turns a simple valid/ready request (read or write, 16-bit address, 8-bit data) into the CE/CSB/WEB/OEB/ADDR/IDATA pin sequence, captures ODATA on reads, and returns a completion pulse with read data.
- Replaces bench-driven pin wiggling so on-chip logic (BIST sequencer, CPU bridge) can drive MEMCTRL. Sits between the requester and MEMCTRL's pin-level inputs.

---
 rtl/memctrl_pkg.sv | 32 +++
 rtl/memctrl_phase_cnt.sv | 34 +++
 rtl/memctrl_host_master.sv | 187 ++++++++++++++++++
 tb/tb_memctrl_host_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared definitions for the MEMCTRL host-side initiator and
// related on-chip requesters (BIST sequencer).
//   - state_t         : host master transaction state encoding
//   - CE_HALF_DEFAULT : default CLK cycles per CE half-period
//   - *_IDLE          : pin values driven when no transaction is in flight
//   - ce_high         : which states drive CE high
package memctrl_pkg;

  localparam int CE_HALF_DEFAULT = 3;
  localparam int AW_DEFAULT      = 16;
  localparam int DW_DEFAULT      = 8;

  localparam logic CE_IDLE  = 1'b0;
  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;
  localparam logic OEB_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PH1_HI = 3'd2,
    PH1_LO = 3'd3,
    PH2_HI = 3'd4,
    PH2_LO = 3'd5
  } state_t;

  // CE is high in SETUP and in both high half-periods.
  function automatic logic ce_high(input state_t s);
    return (s == SETUP) || (s == PH1_HI) || (s == PH2_HI);
  endfunction

endpackage

// File: rtl/memctrl_phase_cnt.sv
// memctrl_phase_cnt: loadable 4-bit down-counter used to time CE half-periods.
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   synchronous active-low reset (count -> 0)
//   load     in   load strobe, has priority over counting
//   load_val in   value loaded on load
//   zero     out  count register equals zero
// The counter decrements every cycle and saturates at zero.
module memctrl_phase_cnt (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Count register: load, else decrement towards zero, else hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/memctrl_host_master.sv
// memctrl_host_master: converts a valid/ready read/write request into the
// MEMCTRL pin sequence (CE/CSB/WEB/OEB/ADDR/IDATA), captures ODATA on reads
// and pulses done at the end of every transaction.
// Ports:
//   CLK, RSTN            clock, synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we/addr/wdata    request fields, latched on accept
//   done                 one-cycle completion pulse
//   rdata                last captured read data
//   busy                 transaction in flight
//   CE/CSB/WEB/OEB/ADDR/IDATA  registered pins to MEMCTRL
//   ODATA                read data from MEMCTRL
// All outputs except req_ready are registered. Pin registers are loaded with
// the values belonging to the state being entered, so the pins line up with
// the state register cycle for cycle.
module memctrl_host_master
  import memctrl_pkg::*;
#(
  parameter int CE_HALF = CE_HALF_DEFAULT,
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          CE,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] IDATA,
  input  logic [DW-1:0] ODATA
);

  // SETUP already supplies one CE-high cycle, so the first high phase is one short.
  localparam logic [3:0] LOAD_FIRST = 4'(CE_HALF - 2);
  localparam logic [3:0] LOAD_HALF  = 4'(CE_HALF - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic       we_r;
  logic       we_nxt_s;
  logic       accept_s;
  logic       cnt_load_s;
  logic [3:0] cnt_val_s;
  logic       cnt_zero_s;
  logic       ce_s;
  logic       csb_s;
  logic       web_s;
  logic       oeb_s;
  logic       done_s;
  logic       busy_s;
  logic       capture_s;

  memctrl_phase_cnt u_phase_cnt (
    .clk      (CLK),
    .rstn     (RSTN),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  assign req_ready = (state_r == IDLE);

  // Next-state, counter load and next pin values.
  always_comb begin
    state_nxt_s = state_r;
    cnt_load_s  = 1'b0;
    cnt_val_s   = 4'd0;
    accept_s    = req_valid && (state_r == IDLE);
    capture_s   = 1'b0;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s = PH1_HI;
        cnt_load_s  = 1'b1;
        cnt_val_s   = LOAD_FIRST;
      end
      PH1_HI: begin
        if (cnt_zero_s) begin
          state_nxt_s = PH1_LO;
          cnt_load_s  = 1'b1;
          cnt_val_s   = LOAD_HALF;
        end else begin
          state_nxt_s = PH1_HI;
        end
      end
      PH1_LO: begin
        if (cnt_zero_s) begin
          state_nxt_s = PH2_HI;
          cnt_load_s  = 1'b1;
          cnt_val_s   = LOAD_HALF;
          capture_s   = !we_r;
        end else begin
          state_nxt_s = PH1_LO;
        end
      end
      PH2_HI: begin
        if (cnt_zero_s) begin
          state_nxt_s = PH2_LO;
          cnt_load_s  = 1'b1;
          cnt_val_s   = LOAD_HALF;
        end else begin
          state_nxt_s = PH2_HI;
        end
      end
      PH2_LO: begin
        if (cnt_zero_s) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = PH2_LO;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // On accept the latched direction is not yet valid; use the request field.
    if (accept_s) begin
      we_nxt_s = req_we;
    end else begin
      we_nxt_s = we_r;
    end

    ce_s   = ce_high(state_nxt_s);
    csb_s  = (state_nxt_s != SETUP);
    web_s  = !((state_nxt_s == SETUP) && we_nxt_s);
    // Output enable spans SETUP through PH1_LO for reads only.
    oeb_s  = !(!we_nxt_s && ((state_nxt_s == SETUP) ||
                             (state_nxt_s == PH1_HI) ||
                             (state_nxt_s == PH1_LO)));
    busy_s = (state_nxt_s != IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      CE      <= CE_IDLE;
      CSB     <= CSB_IDLE;
      WEB     <= WEB_IDLE;
      OEB     <= OEB_IDLE;
      ADDR    <= {AW{1'b0}};
      IDATA   <= {DW{1'b0}};
      done    <= 1'b0;
      rdata   <= {DW{1'b0}};
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      CE      <= ce_s;
      CSB     <= csb_s;
      WEB     <= web_s;
      OEB     <= oeb_s;
      done    <= done_s;
      busy    <= busy_s;
      if (accept_s) begin
        we_r <= req_we;
        ADDR <= req_addr;
        if (req_we) begin
          IDATA <= req_wdata;
        end
      end
      if (capture_s) begin
        rdata <= ODATA;
      end
    end
  end

endmodule

// File: tb/tb_memctrl_host_master.sv
// Directed bench for memctrl_host_master: a default build (CE_HALF=3) and a
// CE_HALF=2 build share one MEMCTRL memory model; sel2 picks which one the
// stimulus and observation address.
module tb_memctrl_host_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        sel2;

  logic        ready1, done1, busy1, ce1, csb1, web1, oeb1;
  logic [7:0]  rdata1, idata1;
  logic [15:0] addr1;
  logic        ready2, done2, busy2, ce2, csb2, web2, oeb2;
  logic [7:0]  rdata2, idata2;
  logic [15:0] addr2;

  logic        valid1, valid2;
  logic        o_ready, o_done, o_busy, o_ce, o_csb, o_web, o_oeb;
  logic [7:0]  o_rdata, o_idata;
  logic [15:0] o_addr;

  logic [7:0]  odata;
  logic        force_en;
  logic [7:0]  force_val;
  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign valid1 = req_valid && !sel2;
  assign valid2 = req_valid && sel2;

  memctrl_host_master dut (
    .CLK(clk), .RSTN(rstn), .req_valid(valid1), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done1), .rdata(rdata1), .busy(busy1), .CE(ce1), .CSB(csb1),
    .WEB(web1), .OEB(oeb1), .ADDR(addr1), .IDATA(idata1), .ODATA(odata)
  );

  memctrl_host_master #(.CE_HALF(2)) dut2 (
    .CLK(clk), .RSTN(rstn), .req_valid(valid2), .req_ready(ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done2), .rdata(rdata2), .busy(busy2), .CE(ce2), .CSB(csb2),
    .WEB(web2), .OEB(oeb2), .ADDR(addr2), .IDATA(idata2), .ODATA(odata)
  );

  assign o_ready = sel2 ? ready2 : ready1;
  assign o_done  = sel2 ? done2  : done1;
  assign o_busy  = sel2 ? busy2  : busy1;
  assign o_ce    = sel2 ? ce2    : ce1;
  assign o_csb   = sel2 ? csb2   : csb1;
  assign o_web   = sel2 ? web2   : web1;
  assign o_oeb   = sel2 ? oeb2   : oeb1;
  assign o_rdata = sel2 ? rdata2 : rdata1;
  assign o_idata = sel2 ? idata2 : idata1;
  assign o_addr  = sel2 ? addr2  : addr1;

  // MEMCTRL model: write on a CSB/WEB-low cycle, drive data while OEB is low.
  always @(posedge clk) begin
    if (!o_csb && !o_web) mem[o_addr[7:0]] <= o_idata;
  end
  assign odata = force_en ? force_val : (o_oeb ? 8'h00 : mem[o_addr[7:0]]);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction; traces hold one bit per cycle after the accept edge.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input int flip_n, input bit glitch, output int done_n,
                         output logic [31:0] ce_t, output logic [31:0] csb_t,
                         output logic [31:0] web_t, output logic [31:0] oeb_t,
                         output logic [31:0] busy_t);
    done_n = 0;
    ce_t = 32'd0; csb_t = 32'd0; web_t = 32'd0; oeb_t = 32'd0; busy_t = 32'd0;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_addr = 16'hFFFF; req_wdata = 8'hEE; req_we = ~we;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) step();
      if (n == flip_n) force_val = 8'hFF;
      if (glitch && n == 2) begin
        rstn = 1'b0; #2; rstn = 1'b1;
      end
      ce_t[n-1]   = o_ce;
      csb_t[n-1]  = !o_csb;
      web_t[n-1]  = !o_web;
      oeb_t[n-1]  = !o_oeb;
      busy_t[n-1] = o_busy;
      if (o_done) begin
        done_n = n;
        break;
      end
    end
  endtask

  initial begin
    int          dn;
    logic [31:0] ce_t, csb_t, web_t, oeb_t, busy_t;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    sel2 = 1'b0; force_en = 1'b0; force_val = 8'h00;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
    rstn = 1'b0;
    step(); step();
    check_eq("rst_ce", o_ce, 1'b0);
    check_eq("rst_csb", o_csb, 1'b1);
    check_eq("rst_web", o_web, 1'b1);
    check_eq("rst_oeb", o_oeb, 1'b1);
    check_eq("rst_addr", o_addr, 16'h0000);
    check_eq("rst_busy_done", {o_busy, o_done}, 2'b00);
    check_eq("rst_rdata", o_rdata, 8'h00);
    check_eq("rst_ready", o_ready, 1'b1);
    rstn = 1'b1;
    step();

    // Write 0x1234 <- 0xA5
    run_txn(1'b1, 16'h1234, 8'hA5, 0, 1'b0, dn, ce_t, csb_t, web_t, oeb_t, busy_t);
    check_eq("wr_done_cyc", dn, 13);
    check_eq("wr_ce_trace", ce_t, 32'h1C7);
    check_eq("wr_csb_trace", csb_t, 32'h001);
    check_eq("wr_web_trace", web_t, 32'h001);
    check_eq("wr_oeb_trace", oeb_t, 32'h000);
    check_eq("wr_busy_trace", busy_t, 32'h0FFF);
    check_eq("wr_addr_hold", o_addr, 16'h1234);
    check_eq("wr_idata", o_idata, 8'hA5);

    // Read 0x1234
    run_txn(1'b0, 16'h1234, 8'h00, 0, 1'b0, dn, ce_t, csb_t, web_t, oeb_t, busy_t);
    check_eq("rd_done_cyc", dn, 13);
    check_eq("rd_ce_trace", ce_t, 32'h1C7);
    check_eq("rd_web_trace", web_t, 32'h000);
    check_eq("rd_oeb_trace", oeb_t, 32'h03F);
    check_eq("rd_rdata", o_rdata, 8'hA5);

    // Write 0x5A leaves rdata alone
    run_txn(1'b1, 16'h1234, 8'h5A, 0, 1'b0, dn, ce_t, csb_t, web_t, oeb_t, busy_t);
    check_eq("wr2_done_cyc", dn, 13);
    check_eq("wr2_rdata_keep", o_rdata, 8'hA5);

    // Back-to-back: WR 0x0000/0x11 then RD 0x0000 with req_valid held
    req_we = 1'b1; req_addr = 16'h0000; req_wdata = 8'h11; req_valid = 1'b1;
    step();
    req_we = 1'b0;
    dn = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) step();
      if (o_done) begin dn = n; break; end
    end
    check_eq("b2b_first_done", dn, 13);
    check_eq("b2b_ready_at_done", o_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check_eq("b2b_second_accept", {o_busy, o_csb}, 2'b10);
    dn = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) step();
      if (o_done) begin dn = n; break; end
    end
    check_eq("b2b_second_done", dn, 13);
    check_eq("b2b_rdata", o_rdata, 8'h11);

    // Reset during PH1_LO of a write
    req_we = 1'b1; req_addr = 16'h0077; req_wdata = 8'h99; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    check_eq("mid_in_ph1lo", {o_ce, o_busy}, 2'b01);
    rstn = 1'b0;
    step();
    check_eq("mid_rst_pins", {o_ce, o_csb, o_web, o_oeb}, 4'b0111);
    check_eq("mid_rst_addr", o_addr, 16'h0000);
    check_eq("mid_rst_busy_done", {o_busy, o_done}, 2'b00);
    rstn = 1'b1;
    req_we = 1'b0; req_addr = 16'h0000; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_eq("post_rst_accept", {o_busy, o_csb, o_oeb}, 3'b100);
    dn = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) step();
      if (o_done) begin dn = n; break; end
    end
    check_eq("post_rst_done", dn, 13);
    check_eq("post_rst_rdata", o_rdata, 8'h11);

    // ODATA stability, with a reset glitch between edges mid-transaction
    force_en = 1'b1; force_val = 8'h3C;
    run_txn(1'b0, 16'h0055, 8'h00, 7, 1'b1, dn, ce_t, csb_t, web_t, oeb_t, busy_t);
    check_eq("stab_done_cyc", dn, 13);
    check_eq("stab_rdata", o_rdata, 8'h3C);
    force_en = 1'b0;
    step();

    // CE_HALF=2 build
    sel2 = 1'b1;
    run_txn(1'b0, 16'h0000, 8'h00, 0, 1'b0, dn, ce_t, csb_t, web_t, oeb_t, busy_t);
    check_eq("h2_done_cyc", dn, 9);
    check_eq("h2_ce_trace", ce_t, 32'h033);
    check_eq("h2_oeb_trace", oeb_t, 32'h00F);
    check_eq("h2_rdata", o_rdata, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
